vga_timing: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the system clock. It divides `clk` down to a pixel-rate tick and runs horizontal and vertical counters. It drives `hsync`, `vsync`, the pixel coordinates `x`/`y` consumed by the downstream `graphic` renderer, a `video_on` blanking flag, and a single-cycle `frame_start` strobe. The strobe replaces the renderer's multi-cycle `x==0 && y==0` frame detection.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing_if.sv | 24 ++
 rtl/pix_tick_gen.sv | 42 ++++
 rtl/vga_timing.sv | 103 ++++++++++
 tb/tb_vga_timing.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz raster constants, used by vga_timing and by the
// graphic renderer for its visible-area bounds.
package vga_pkg;

    // Horizontal segments, in pixels
    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical segments, in lines
    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Active level of hsync/vsync (0 = active-low)
    localparam bit VGA_SYNC_POL = 1'b0;

    // Datapath widths
    localparam int COORD_W = 11;
    localparam int FCNT_W  = 8;
    localparam int DIV_W   = 4;   // holds CLK_DIV-1 for CLK_DIV up to 16

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between vga_timing (master) and its consumers.
interface vga_timing_if;
    import vga_pkg::*;

    logic               en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               pix_tick;
    logic               frame_start;
    logic [FCNT_W-1:0]  frame_cnt;

    modport master (
        input  en,
        output x, y, hsync, vsync, video_on, pix_tick, frame_start, frame_cnt
    );

    modport slave (
        output en,
        input  x, y, hsync, vsync, video_on, pix_tick, frame_start, frame_cnt
    );
endinterface

// File: rtl/pix_tick_gen.sv
// Divides clk by CLK_DIV into a one-cycle pixel tick. A partial count is
// kept while en is low so the tick resumes exactly where it stopped.
module pix_tick_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic pix_tick
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // Next divider count; the tick flop tracks "next count is the last one"
    always_comb begin
        div_d = div_q;
        if (en) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        end
        tick_d = (div_d == DIV_MAX);
    end

    // Divider and tick registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // A held tick flop must not leak out while counting is frozen
    assign pix_tick = tick_q & en;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters, sync and blanking decode, frame
// strobe and frame counter. Decoded outputs are registered from the next
// counter values so they switch on the same edge as x/y.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vif
);

    localparam logic [COORD_W-1:0] H_MAX   = COORD_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_MAX   = COORD_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] H_VIS_W = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] V_VIS_W = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

    logic                tick;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                hsync_q, hsync_d, vsync_q, vsync_d;
    logic                video_on_q, video_on_d;
    logic                frame_start_q, frame_start_d;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (vif.en),
        .pix_tick (tick)
    );

    // Counter advance and decode of the values they will take next
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        if (tick) begin
            if (x_q == H_MAX) begin
                x_d = '0;
                if (y_q == V_MAX) begin
                    y_d         = '0;
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                end else begin
                    y_d = y_q + COORD_W'(1);
                end
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
        hsync_d       = (x_d >= HS_LO && x_d <= HS_HI) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (y_d >= VS_LO && y_d <= VS_HI) ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (x_d < H_VIS_W) && (y_d < V_VIS_W);
        // Only a real wrap sets the strobe, so the post-reset (0,0) is silent
        frame_start_d = tick && (x_q == H_MAX) && (y_q == V_MAX);
    end

    // Counter and decoded-output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q           <= '0;
            y_q           <= '0;
            frame_cnt_q   <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.frame_cnt   = frame_cnt_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.video_on    = video_on_q;
    assign vif.pix_tick    = tick;
    assign vif.frame_start = frame_start_q & vif.en;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a full-size instance (CLK_DIV=4) for line,
// enable and reset behaviour, and a shrunken CLK_DIV=1 instance (16x10 raster)
// so whole frames and the frame_cnt wrap fit in a short run.
module tb_vga_timing;

    logic clk     = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Bench bookkeeping
    int          last_tick, hs_low, last_wrap, n_fs, guard;
    logic        prev_fs;
    logic [10:0] prev_ax, prev_bx;

    vga_timing_if va ();
    vga_timing_if vb ();

    vga_timing #(
        .CLK_DIV (4)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a_n),
        .vif   (va)
    );

    // Small raster: H 8/2/3/3 (total 16, hsync x=10..12), V 6/1/2/1 (total 10, vsync y=7..8)
    vga_timing #(
        .CLK_DIV (1),
        .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VIS (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b_n),
        .vif   (vb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        va.en = 1'b1;
        vb.en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        check("a_rst_x",   32'(va.x), 0);
        check("a_rst_y",   32'(va.y), 0);
        check("a_rst_hs",  32'(va.hsync), 1);
        check("a_rst_vs",  32'(va.vsync), 1);
        check("a_rst_vid", 32'(va.video_on), 1);
        check("a_rst_pt",  32'(va.pix_tick), 0);
        check("a_rst_fs",  32'(va.frame_start), 0);
        check("a_rst_fc",  32'(va.frame_cnt), 0);
        check("b_rst_x",   32'(vb.x), 0);
        check("b_rst_fc",  32'(vb.frame_cnt), 0);

        // ---- Small instance: two full frames at CLK_DIV=1 ----
        rst_b_n   = 1'b1;
        n_fs      = 0;
        last_wrap = -1;
        prev_fs   = 1'b0;
        prev_bx   = '0;
        for (int c = 1; c <= 330; c++) begin
            @(negedge clk);
            check("b_tick_const", 32'(vb.pix_tick), 1);
            check("b_hsync", 32'(vb.hsync),    (vb.x >= 10 && vb.x <= 12) ? 0 : 1);
            check("b_vsync", 32'(vb.vsync),    (vb.y >= 7 && vb.y <= 8) ? 0 : 1);
            check("b_video", 32'(vb.video_on), (vb.x < 8 && vb.y < 6) ? 1 : 0);
            if (vb.x == 0 && prev_bx != 0) begin
                if (last_wrap >= 0) check("b_line_period", 32'(c - last_wrap), 16);
                last_wrap = c;
            end
            if (vb.frame_start) begin
                n_fs++;
                check("b_fs_xy",    32'({vb.x, vb.y}), 0);
                check("b_fs_width", 32'(prev_fs), 0);
                check("b_fs_time",  32'(c), 32'(1 + 160 * n_fs));
                check("b_fs_fcnt",  32'(vb.frame_cnt), 32'(n_fs));
            end
            prev_fs = vb.frame_start;
            prev_bx = vb.x;
        end
        check("b_fs_count", 32'(n_fs), 2);
        check("b_fcnt_2",   32'(vb.frame_cnt), 2);

        // ---- Small instance: frame_cnt 255 -> 0 together with x/y wrap ----
        guard = 0;
        while (!(vb.frame_cnt == 255 && vb.x == 15 && vb.y == 9) && guard < 45000) begin
            @(negedge clk);
            guard++;
        end
        check("b_reach_255", 32'(guard < 45000), 1);
        @(negedge clk);
        check("b_wrap_x",  32'(vb.x), 0);
        check("b_wrap_y",  32'(vb.y), 0);
        check("b_wrap_fc", 32'(vb.frame_cnt), 0);
        check("b_wrap_fs", 32'(vb.frame_start), 1);
        @(negedge clk);
        check("b_wrap_fs_off", 32'(vb.frame_start), 0);
        check("b_wrap_x1",     32'(vb.x), 1);

        // ---- Small instance: async reset mid-frame inside both sync pulses ----
        guard = 0;
        while (!(vb.frame_cnt == 1 && vb.x == 11 && vb.y == 7) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("b_reach_mid", 32'(guard < 400), 1);
        check("b_pre_hs",    32'(vb.hsync), 0);
        rst_b_n = 1'b0;
        #1;
        check("b_arst_x",   32'(vb.x), 0);
        check("b_arst_y",   32'(vb.y), 0);
        check("b_arst_hs",  32'(vb.hsync), 1);
        check("b_arst_vs",  32'(vb.vsync), 1);
        check("b_arst_vid", 32'(vb.video_on), 1);
        check("b_arst_fs",  32'(vb.frame_start), 0);
        check("b_arst_fc",  32'(vb.frame_cnt), 0);
        check("b_arst_pt",  32'(vb.pix_tick), 0);

        // ---- Full instance: first line at CLK_DIV=4 ----
        @(negedge clk);
        rst_a_n   = 1'b1;
        last_tick = -1;
        hs_low    = 0;
        prev_ax   = '0;
        for (int c = 0; c < 4000 && va.y != 1; c++) begin
            @(negedge clk);
            if (va.pix_tick) begin
                if (last_tick >= 0) check("a_tick_period", 32'(c - last_tick), 4);
                last_tick = c;
                if (!va.hsync) hs_low++;
            end
            if (va.x != prev_ax) begin
                check("a_hsync", 32'(va.hsync),    (va.x >= 656 && va.x <= 751) ? 0 : 1);
                check("a_video", 32'(va.video_on), (va.x < 640) ? 1 : 0);
                check("a_vsync", 32'(va.vsync), 1);
                if (prev_ax == 799) begin
                    check("a_wrap_x", 32'(va.x), 0);
                    check("a_wrap_y", 32'(va.y), 1);
                end else begin
                    check("a_x_step", 32'(va.x), 32'(prev_ax) + 1);
                    check("a_y_hold", 32'(va.y), 0);
                end
                prev_ax = va.x;
            end
        end
        check("a_line_done", 32'(va.y), 1);
        check("a_line_x0",   32'(va.x), 0);
        check("a_hs_ticks",  32'(hs_low), 96);

        // ---- Full instance: freeze with en=0 at div=2, x=100 ----
        guard = 0;
        while (va.x != 100 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("a_reach_100", 32'(guard < 1000), 1);
        repeat (2) @(negedge clk);   // divider now at 2
        check("a_pre_en_pt", 32'(va.pix_tick), 0);
        va.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a_hold_x",   32'(va.x), 100);
            check("a_hold_y",   32'(va.y), 1);
            check("a_hold_pt",  32'(va.pix_tick), 0);
            check("a_hold_vid", 32'(va.video_on), 1);
        end
        va.en = 1'b1;
        @(negedge clk);
        check("a_resume_pt", 32'(va.pix_tick), 1);
        check("a_resume_x",  32'(va.x), 100);
        @(negedge clk);
        check("a_resume_x1",  32'(va.x), 101);
        check("a_resume_pt0", 32'(va.pix_tick), 0);

        // ---- Full instance: async reset at x=700 (inside hsync) ----
        guard = 0;
        while (va.x != 700 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("a_reach_700", 32'(guard < 3000), 1);
        check("a_pre_hs",    32'(va.hsync), 0);
        check("a_pre_vid",   32'(va.video_on), 0);
        rst_a_n = 1'b0;
        #1;
        check("a_arst_x",   32'(va.x), 0);
        check("a_arst_y",   32'(va.y), 0);
        check("a_arst_hs",  32'(va.hsync), 1);
        check("a_arst_vs",  32'(va.vsync), 1);
        check("a_arst_vid", 32'(va.video_on), 1);
        check("a_arst_fs",  32'(va.frame_start), 0);
        check("a_arst_fc",  32'(va.frame_cnt), 0);
        check("a_arst_pt",  32'(va.pix_tick), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
